// File: rtl/matrix_mult_engine_pkg.sv
// mm_pkg: shared constants, FSM state type and operand indexing helpers
// for the 3x3 byte matrix multiply engine.
//   DATA_W : operand element width (unsigned bytes)
//   DIM    : matrix dimension
//   ACC_W  : accumulator width, wide enough for DIM products without overflow
//   NBYTES : bytes emitted per result element
//   OPND_W : width of the flattened operand bus (A then B, row-major)
package mm_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIM    = 3;
  localparam int unsigned ACC_W  = 2 * DATA_W + 2;
  localparam int unsigned NBYTES = 3;
  localparam int unsigned EXT_W  = NBYTES * DATA_W;
  localparam int unsigned OPND_W = 2 * DIM * DIM * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    EMIT,
    FINISH
  } state_t;

  // Byte offset of A[i][k] within the operand bus.
  function automatic int unsigned a_off(input logic [1:0] i, input logic [1:0] k);
    return 32'(i) * DIM + 32'(k);
  endfunction

  // Byte offset of B[k][j] within the operand bus (B follows the nine A bytes).
  function automatic int unsigned b_off(input logic [1:0] k, input logic [1:0] j);
    return DIM * DIM + 32'(k) * DIM + 32'(j);
  endfunction

  // Byte idx of a result, zero-extended above ACC_W.
  function automatic logic [DATA_W-1:0] res_byte(input logic [ACC_W-1:0] res,
                                                 input logic [1:0]       idx);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(res);
    return ext[DATA_W*32'(idx) +: DATA_W];
  endfunction

endpackage

// File: rtl/matrix_mult_engine_mac.sv
// mm_mac: registered unsigned multiply-accumulate.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   clr        : restart accumulation (with en: load a*b, without: load 0)
//   en         : accumulate a*b this cycle
//   a, b       : unsigned operand bytes
//   acc        : registered accumulator
module mm_mac
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] prod;

  assign prod = ACC_W'(a) * ACC_W'(b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= en ? prod : '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/matrix_mult_engine.sv
// matrix_mult_engine: computes C = A x B for unsigned 3x3 byte matrices with
// one MAC and streams the nine results as little-endian byte triplets.
// Ports:
//   clk       : clock
//   reset     : asynchronous active-low reset
//   start     : rising edge launches one computation (from collector done)
//   operands  : bytes 0-8 A row-major, bytes 9-17 B row-major
//   out_data  : current result byte
//   out_valid : out_data valid
//   out_ready : consumer accepts the byte
//   out_last  : final byte of C[2][2]
//   busy      : computing or emitting
//   done      : run finished, held until start drops
module matrix_mult_engine
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OPND_W-1:0] operands,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t             state_q;
  logic               start_q;
  logic [OPND_W-1:0]  ops_q;
  logic [1:0]         i_q, j_q, k_q, byte_q;
  logic               out_valid_q, busy_q, done_q;

  logic               start_edge;
  logic               xfer;
  logic               mac_clr, mac_en;
  logic [DATA_W-1:0]  a_w, b_w;
  logic [ACC_W-1:0]   acc_w;

  assign start_edge = start & ~start_q;
  assign xfer       = out_valid_q & out_ready;

  assign a_w = ops_q[DATA_W*a_off(i_q, k_q) +: DATA_W];
  assign b_w = ops_q[DATA_W*b_off(k_q, j_q) +: DATA_W];

  // The accumulator restarts on the k=0 product instead of being cleared at
  // k=2, so it holds the finished sum through EMIT and doubles as the result.
  assign mac_en  = (state_q == CALC);
  assign mac_clr = (state_q == IDLE) | ((state_q == CALC) & (k_q == 2'd0));

  mm_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (a_w),
    .b     (b_w),
    .acc   (acc_w)
  );

  assign out_data  = res_byte(acc_w, byte_q);
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q & (i_q == 2'd2) & (j_q == 2'd2) & (byte_q == 2'd2);
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      ops_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      byte_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            ops_q   <= operands;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end

        CALC: begin
          if (k_q == 2'd2) begin
            k_q         <= '0;
            byte_q      <= '0;
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end

        EMIT: begin
          if (xfer) begin
            if (byte_q == 2'd2) begin
              out_valid_q <= 1'b0;
              byte_q      <= '0;
              if ((i_q == 2'd2) && (j_q == 2'd2)) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= FINISH;
              end else begin
                if (j_q == 2'd2) begin
                  j_q <= '0;
                  i_q <= i_q + 2'd1;
                end else begin
                  j_q <= j_q + 2'd1;
                end
                state_q <= CALC;
              end
            end else begin
              byte_q <= byte_q + 2'd1;
            end
          end
        end

        FINISH: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_engine.sv
module tb_matrix_mult_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [143:0] operands;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         done;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  logic [7:0]   exp_q[$];

  always #5 clk = ~clk;

  matrix_mult_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operands  (operands),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain matrix product, each element split into three LE bytes.
  function automatic void build_expected(input logic [143:0] ops);
    int unsigned a[3][3];
    int unsigned b[3][3];
    int unsigned s;
    exp_q.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a[r][c] = int'(ops[8*(r*3+c) +: 8]);
        b[r][c] = int'(ops[8*(9+r*3+c) +: 8]);
      end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        s = 0;
        for (int m = 0; m < 3; m++) s += a[r][m] * b[m][c];
        exp_q.push_back(s[7:0]);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[23:16]);
      end
  endfunction

  function automatic logic [143:0] rand_ops();
    logic [143:0] v;
    for (int k = 0; k < 18; k++) v[8*k +: 8] = 8'($urandom);
    return v;
  endfunction

  // Raise start at a negedge; returns at the negedge after the 3rd CALC edge.
  task automatic launch(input logic [143:0] ops);
    operands = ops;
    build_expected(ops);
    start = 1'b1;
    @(negedge clk);
    check("busy_after_launch", busy, 1);
    @(negedge clk);
    @(negedge clk);
    check("valid_before_lat3", out_valid, 0);
    @(negedge clk);
    check("valid_at_lat3", out_valid, 1);
  endtask

  // Consume stop_after bytes, checking values, stalls and out_last.
  task automatic run_stream(input bit rnd, input int stop_after);
    int         cyc = 3;
    int         got = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    while (got < stop_after && cyc < 3000) begin
      out_ready = rnd ? ($urandom_range(0, 1) == 0) : 1'b1;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (!out_valid) check("last_without_valid", out_last, 0);
      if (out_valid && out_ready) begin
        check($sformatf("byte%0d", got), out_data, exp_q[got]);
        check($sformatf("last%0d", got), out_last, (got == 26));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clk);
      cyc++;
    end
    if (got < stop_after) check("stream_timeout", got, stop_after);
    if (stop_after == 27 && got == 27) begin
      check("done_after_last", done, 1);
      check("valid_after_last", out_valid, 0);
      check("busy_after_last", busy, 0);
      if (!rnd) check("best_case_cycles", cyc, 54);
    end
  endtask

  task automatic no_rerun_check();
    bit any_valid = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid || busy) any_valid = 1'b1;
    end
    check("held_start_no_rerun", any_valid, 0);
    check("held_start_done", done, 1);
  endtask

  task automatic drop_start();
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [143:0] ops_seq;
  logic [143:0] ops_id;
  logic [143:0] ops_ff;

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    operands  = '0;
    for (int k = 0; k < 9; k++) begin
      ops_seq[8*k +: 8]     = 8'(k + 1);
      ops_seq[8*(9+k) +: 8] = 8'(9 - k);
      ops_id[8*k +: 8]      = (k % 4 == 0) ? 8'd1 : 8'd0;
      ops_id[8*(9+k) +: 8]  = 8'(k + 1);
    end
    ops_ff = '1;

    repeat (3) @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    // 1..9 x 9..1, full rate, then start held high
    launch(ops_seq);
    run_stream(1'b0, 27);
    no_rerun_check();
    drop_start();

    // identity x 1..9
    launch(ops_id);
    run_stream(1'b0, 27);
    drop_start();

    // all 0xFF
    launch(ops_ff);
    run_stream(1'b0, 27);
    drop_start();

    // 1..9 x 9..1 with random back-pressure
    launch(ops_seq);
    run_stream(1'b1, 27);
    drop_start();

    // reset during EMIT of element 4, then a fresh run
    launch(ops_seq);
    run_stream(1'b0, 10);
    check("emit_before_reset", out_valid, 1);
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_out_data", out_data, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    launch(ops_seq);
    run_stream(1'b0, 27);
    drop_start();

    // new operands, mid-run operand change and a start re-edge while busy
    launch(rand_ops());
    out_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    operands = rand_ops();
    @(negedge clk);
    run_stream(1'b1, 27);
    no_rerun_check();
    drop_start();

    // random operands, random back-pressure
    for (int r = 0; r < 4; r++) begin
      launch(rand_ops());
      operands = rand_ops();
      run_stream(1'b1, 27);
      drop_start();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
